// File: rtl/vram_slot_arbiter.sv
// Shares one VDC VRAM port between BG fetch, sprite fetch, CPU and DMA.
// One access in flight; read data is routed back through a latency-matched tag pipe.
module vram_slot_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int ACC_CYC  = 2,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [DATA_W-1:0] MD_in,
    output logic [3:0]        gnt,
    output logic [3:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] MA,
    output logic [DATA_W-1:0] MD_out,
    output logic              MRD_n,
    output logic              MWR_n,
    output logic              busy
);

    localparam int CNT_W  = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(ACC_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic { S_IDLE, S_ACCESS } state_e;
    typedef enum logic [1:0] { OWN_BG, OWN_SPR, OWN_CPU, OWN_DMA } owner_e;

    function automatic logic [3:0] onehot(input owner_e o);
        return 4'b0001 << o;
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    owner_e              owner_q, win;
    logic                we_q, win_we;
    logic [ADDR_W-1:0]   ma_q, win_addr;
    logic [DATA_W-1:0]   md_out_q, win_wdata, rdata_q;
    logic [WAIT_W-1:0]   cpu_wait_q, dma_wait_q;
    logic                rr_q;        // 0: CPU is next in the CPU/DMA rotation
    logic [RD_LAT-1:0]   tag_v_q;
    owner_e              tag_own_q [RD_LAT];
    logic [3:0]          rvalid_q;
    logic                any_req, arb_en, start;

    // Arbitration: starving CPU/DMA first, then BG, SPR, then CPU/DMA round-robin.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        win       = OWN_BG;
        win_we    = 1'b0;
        win_addr  = bg_addr;
        win_wdata = '0;
        any_req   = bg_req | spr_req | cpu_req | dma_req;
        arb_en    = (state_q == S_IDLE) || (cnt_q == LAST);
        start     = arb_en && any_req;

        if (cpu_req && cpu_wait_q == WAIT_MAX)          win = OWN_CPU;
        else if (dma_req && dma_wait_q == WAIT_MAX)     win = OWN_DMA;
        else if (bg_req)                                win = OWN_BG;
        else if (spr_req)                               win = OWN_SPR;
        else if (cpu_req && (!dma_req || !rr_q))        win = OWN_CPU;
        else if (dma_req)                               win = OWN_DMA;

        case (win)
            OWN_BG:  win_addr = bg_addr;
            OWN_SPR: win_addr = spr_addr;
            OWN_CPU: begin
                win_addr  = cpu_addr;
                win_we    = cpu_we;
                win_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                win_addr  = dma_addr;
                win_we    = dma_we;
                win_wdata = dma_wdata;
            end
            default: win_addr = bg_addr;
        endcase
    end

    // Next state: the last access cycle re-arbitrates so grants run back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (arb_en) begin
            state_d = start ? S_ACCESS : S_IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_BG;
            we_q       <= 1'b0;
            ma_q       <= '0;
            md_out_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            cpu_wait_q <= '0;
            dma_wait_q <= '0;
            rr_q       <= 1'b0;
            // NOTE: the tag pipe is reset, not left as plain storage, so reads in flight are dropped.
            tag_v_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_own_q[i] <= OWN_BG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (start) begin
                owner_q <= win;
                we_q    <= win_we;
                ma_q    <= win_addr;
                if (win_we) md_out_q <= win_wdata;
                if (win == OWN_CPU) rr_q <= 1'b1;
                if (win == OWN_DMA) rr_q <= 1'b0;
            end

            if (!cpu_req || (start && win == OWN_CPU)) cpu_wait_q <= '0;
            else if (cpu_wait_q != WAIT_MAX)           cpu_wait_q <= cpu_wait_q + 1'b1;
            if (!dma_req || (start && win == OWN_DMA)) dma_wait_q <= '0;
            else if (dma_wait_q != WAIT_MAX)           dma_wait_q <= dma_wait_q + 1'b1;

            tag_v_q[0]   <= start && !win_we;
            tag_own_q[0] <= win;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end

            rvalid_q <= tag_v_q[RD_LAT-1] ? onehot(tag_own_q[RD_LAT-1]) : 4'b0000;
            if (tag_v_q[RD_LAT-1]) rdata_q <= MD_in;
        end
    end

    always_comb begin
        busy   = (state_q == S_ACCESS);
        gnt    = (busy && cnt_q == '0) ? onehot(owner_q) : 4'b0000;
        MRD_n  = !(busy && !we_q);
        MWR_n  = !(busy && we_q);
        MA     = ma_q;
        MD_out = md_out_q;
        rdata  = rdata_q;
        rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: single-access vector table plus
// sequences for simultaneous requests, starvation, CPU/DMA rotation and reset mid-read.
module tb_vram_slot_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        bg_req, spr_req, cpu_req, dma_req, cpu_we, dma_we;
    logic [15:0] bg_addr, spr_addr, cpu_addr, dma_addr, cpu_wdata, dma_wdata;
    logic [15:0] MD_in, rdata, MA, MD_out;
    logic [3:0]  gnt, rvalid;
    logic        MRD_n, MWR_n, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // VRAM model: read data is a fixed scramble of the address on the pins.
    assign MD_in = MA ^ 16'h5A3C;

    vram_slot_arbiter dut (
        .clock(clock), .reset(reset),
        .bg_req(bg_req), .bg_addr(bg_addr),
        .spr_req(spr_req), .spr_addr(spr_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .MD_in(MD_in), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .MA(MA), .MD_out(MD_out), .MRD_n(MRD_n), .MWR_n(MWR_n), .busy(busy)
    );

    typedef struct {
        int          id;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rvalid;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        case (id)
            0: begin bg_req = v; bg_addr = a; end
            1: begin spr_req = v; spr_addr = a; end
            2: begin cpu_req = v; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
            default: begin dma_req = v; dma_we = we; dma_addr = a; dma_wdata = d; end
        endcase
    endtask

    task automatic drop(input logic [3:0] g);
        if (g[0]) bg_req = 1'b0;
        if (g[1]) spr_req = 1'b0;
        if (g[2]) cpu_req = 1'b0;
        if (g[3]) dma_req = 1'b0;
    endtask

    logic [3:0] exp_g2 [8];
    logic [3:0] exp_r2 [8];
    int bg_cnt, cpu_lat;

    initial begin
        vecs[0] = '{0, 1'b0, 16'h1234, 16'h0000, 4'b0001, 4'b0001, 16'h4808};
        vecs[1] = '{1, 1'b0, 16'h00FF, 16'h0000, 4'b0010, 4'b0010, 16'h5AC3};
        vecs[2] = '{2, 1'b1, 16'h0800, 16'hBEEF, 4'b0100, 4'b0000, 16'h0000};
        vecs[3] = '{2, 1'b0, 16'h0800, 16'h0000, 4'b0100, 4'b0100, 16'h523C};
        vecs[4] = '{3, 1'b1, 16'hFFFF, 16'h1357, 4'b1000, 4'b0000, 16'h0000};
        vecs[5] = '{3, 1'b0, 16'h0001, 16'h0000, 4'b1000, 4'b1000, 16'h5A3D};
        exp_g2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        exp_r2 = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};

        reset = 1'b1;
        bg_req = 0; spr_req = 0; cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
        bg_addr = 0; spr_addr = 0; cpu_addr = 0; dma_addr = 0; cpu_wdata = 0; dma_wdata = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_rvalid", rvalid, 4'b0000);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_ma", MA, 16'h0000);
        check("rst_md_out", MD_out, 16'h0000);
        check("rst_mrd_n", MRD_n, 1'b1);
        check("rst_mwr_n", MWR_n, 1'b1);
        check("rst_busy", busy, 1'b0);

        // Single accesses: grant next cycle, strobe for two cycles, read data RD_LAT after grant.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].id, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            tick();
            check("vec_gnt", gnt, vecs[i].exp_gnt);
            check("vec_ma", MA, vecs[i].addr);
            check("vec_busy", busy, 1'b1);
            check("vec_mrd_n_c0", MRD_n, vecs[i].we);
            check("vec_mwr_n_c0", MWR_n, !vecs[i].we);
            if (vecs[i].we) check("vec_md_out", MD_out, vecs[i].wdata);
            drive(vecs[i].id, 1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            tick();
            check("vec_gnt_pulse", gnt, 4'b0000);
            check("vec_mrd_n_c1", MRD_n, vecs[i].we);
            check("vec_mwr_n_c1", MWR_n, !vecs[i].we);
            tick();
            check("vec_idle_strobes", {MRD_n, MWR_n, busy}, 3'b110);
            check("vec_rvalid", rvalid, vecs[i].exp_rvalid);
            if (vecs[i].exp_rvalid != 4'b0000) check("vec_rdata", rdata, vecs[i].exp_rdata);
            check("vec_ma_hold", MA, vecs[i].addr);
            tick();
            check("vec_rvalid_pulse", rvalid, 4'b0000);
        end

        // All four requesters at once: BG, SPR, CPU, DMA with no dead cycles.
        drive(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        drive(2, 1'b1, 1'b1, 16'h0300, 16'hAAAA);
        drive(3, 1'b1, 1'b1, 16'h0400, 16'h5555);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("all4_gnt", gnt, exp_g2[c]);
            check("all4_rvalid", rvalid, exp_r2[c]);
            check("all4_busy", busy, 1'b1);
            drop(gnt);
        end
        tick();
        check("all4_idle", busy, 1'b0);

        // BG held forever: CPU must be forced in once its wait counter saturates.
        bg_cnt = 0;
        cpu_lat = 0;
        drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(2, 1'b1, 1'b0, 16'h0020, 16'h0000);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (gnt[0]) bg_cnt++;
            if (gnt[2]) begin
                cpu_lat = c;
                cpu_req = 1'b0;
                break;
            end
        end
        check("starve_cpu_latency", cpu_lat, 17);
        check("starve_bg_grants", bg_cnt, 8);
        tick();
        bg_req = 1'b0;
        repeat (4) tick();
        check("starve_idle", busy, 1'b0);

        // CPU and DMA both held: grants alternate starting with CPU after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        drive(2, 1'b1, 1'b1, 16'h0A00, 16'h1111);
        drive(3, 1'b1, 1'b1, 16'h0B00, 16'h2222);
        for (int c = 0; c < 12; c++) begin
            tick();
            check("rr_gnt", gnt, (c % 2 != 0) ? 4'b0000 : ((c % 4 == 0) ? 4'b0100 : 4'b1000));
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (3) tick();
        check("rr_idle", busy, 1'b0);

        // Reset one cycle after a read grant: strobe drops, no grant, no read data ever.
        drive(0, 1'b1, 1'b0, 16'h4321, 16'h0000);
        tick();
        check("rst6_gnt", gnt, 4'b0001);
        bg_req = 1'b0;
        tick();
        check("rst6_mrd_n_active", MRD_n, 1'b0);
        reset = 1'b1;
        bg_req = 1'b1;
        tick();
        check("rst6_mrd_n", MRD_n, 1'b1);
        check("rst6_busy", busy, 1'b0);
        check("rst6_rvalid", rvalid, 4'b0000);
        tick();
        check("rst6_no_gnt", gnt, 4'b0000);
        check("rst6_ma", MA, 16'h0000);
        reset = 1'b0;
        bg_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst6_rvalid_after", rvalid, 4'b0000);
            check("rst6_gnt_after", gnt, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
